// File: rtl/maint_req_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// maint_req_scheduler_pkg
// Shared maintenance package: grant type encodings, scheduler FSM state
// encoding, default refresh postponement limit and pending-vector bit indices.
// Imported by maint_req_scheduler, maint_prio_sel and maint_handler.
// No ports (package).
// -----------------------------------------------------------------------------
package maint_req_scheduler_pkg;

  // Default number of auto-refreshes that may be postponed before a forced grant
  localparam int MAINT_MAX_POSTPONE = 8;
  localparam int MAINT_CNT_WIDTH    = 4;

  // Maintenance operation handed to the instruction generator
  typedef enum logic [1:0] {
    GT_AREF = 2'd0,
    GT_ZQ   = 2'd1,
    GT_PRRD = 2'd2
  } grant_type_e;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2
  } maint_state_e;

  // Bit positions inside the pending vector fed to the priority selector
  localparam int PEND_AREF = 0;
  localparam int PEND_ZQ   = 1;
  localparam int PEND_PRRD = 2;

endpackage

// File: rtl/maint_req_scheduler_prio_sel.sv
// -----------------------------------------------------------------------------
// maint_prio_sel
// Combinational fixed-priority selector for pending maintenance work.
// Priority: urgent AREF, ZQ, PRRD, non-urgent AREF.
// Ports:
//   pend_vec  in  [2:0]  pending work, indexed by PEND_AREF/PEND_ZQ/PEND_PRRD
//   urgent    in         AREF credit counter has reached its postpone limit
//   sel_valid out        some request is pending
//   sel_type  out        winning grant type (GT_AREF when nothing pending)
// -----------------------------------------------------------------------------
module maint_prio_sel
  import maint_req_scheduler_pkg::*;
(
  input  logic [2:0]  pend_vec,
  input  logic        urgent,
  output logic        sel_valid,
  output grant_type_e sel_type
);

  // An urgent refresh outranks everything; a merely pending refresh is
  // the lowest priority so that calibration work is not starved.
  always_comb begin
    sel_valid = 1'b0;
    sel_type  = GT_AREF;
    if (urgent) begin
      sel_valid = 1'b1;
      sel_type  = GT_AREF;
    end else if (pend_vec[PEND_ZQ]) begin
      sel_valid = 1'b1;
      sel_type  = GT_ZQ;
    end else if (pend_vec[PEND_PRRD]) begin
      sel_valid = 1'b1;
      sel_type  = GT_PRRD;
    end else if (pend_vec[PEND_AREF]) begin
      sel_valid = 1'b1;
      sel_type  = GT_AREF;
    end
  end

endmodule

// File: rtl/maint_req_scheduler.sv
// -----------------------------------------------------------------------------
// maint_req_scheduler
// Collects auto-refresh, ZQ calibration and periodic-read requests from the
// maintenance timer, arbitrates them and hands one at a time to the
// maintenance instruction generator over a valid/ack handshake.
// Optional feature macro: MAINT_ZQ_SCHED_EN (ZQ scheduling; when undefined
// zq_req is ignored and zq_ack is tied low).
// Parameters:
//   MAX_POSTPONE  outstanding AREFs that force a grant
//   CNT_WIDTH     credit counter width, 2**CNT_WIDTH must exceed MAX_POSTPONE
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   autoref_req/zq_req/pr_rd_req  request pulses from the timer
//   dispatcher_busy             host sequence owns the command bus
//   grant_valid/grant_type/grant_ack  handshake to the instruction generator
//   grant_done                  granted sequence finished issuing
//   autoref_ack/zq_ack/pr_rd_ack  completion pulses back to the timer
//   aref_pending/aref_urgent/aref_overflow  refresh credit status
// -----------------------------------------------------------------------------
module maint_req_scheduler
  import maint_req_scheduler_pkg::*;
#(
  parameter int MAX_POSTPONE = MAINT_MAX_POSTPONE,
  parameter int CNT_WIDTH    = MAINT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 autoref_req,
  input  logic                 zq_req,
  input  logic                 pr_rd_req,
  input  logic                 dispatcher_busy,
  output logic                 grant_valid,
  output logic [1:0]           grant_type,
  input  logic                 grant_ack,
  input  logic                 grant_done,
  output logic                 autoref_ack,
  output logic                 zq_ack,
  output logic                 pr_rd_ack,
  output logic [CNT_WIDTH-1:0] aref_pending,
  output logic                 aref_urgent,
  output logic                 aref_overflow
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_POSTPONE);

  maint_state_e          state;
  maint_state_e          state_nxt;
  grant_type_e           win_type;
  grant_type_e           sel_type;
  logic                  sel_valid;
  logic [CNT_WIDTH-1:0]  aref_cnt;
  logic                  zq_pend;
  logic                  prrd_pend;
  logic                  start;
  logic                  accept;
  logic                  finish;
  logic                  aref_done;

  maint_prio_sel u_prio_sel (
    .pend_vec  ({prrd_pend, zq_pend, (aref_cnt != '0)}),
    .urgent    (aref_urgent),
    .sel_valid (sel_valid),
    .sel_type  (sel_type)
  );

  // A busy command bus only holds back non-urgent work
  assign start     = (state == ST_IDLE) && sel_valid && (aref_urgent || !dispatcher_busy);
  assign accept    = (state == ST_GRANT) && grant_ack;
  assign finish    = (state == ST_ISSUE) && grant_done;
  assign aref_done = finish && (win_type == GT_AREF);

  assign aref_pending = aref_cnt;
  assign aref_urgent  = (aref_cnt == MAX_CNT);
  assign grant_valid  = (state == ST_GRANT);
  assign grant_type   = grant_valid ? win_type : GT_AREF;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: ack and done are only honoured in their own state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)  state_nxt = ST_GRANT;
      ST_GRANT: if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: if (finish) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Winner is frozen when leaving IDLE so later requests cannot pre-empt it
  always_ff @(posedge clk) begin
    if (rst)        win_type <= GT_AREF;
    else if (start) win_type <= sel_type;
  end

  // Refresh credits: simultaneous request and completion cancel out;
  // a request that finds the counter full is lost and flagged for good
  always_ff @(posedge clk) begin
    if (rst) begin
      aref_cnt      <= '0;
      aref_overflow <= 1'b0;
    end else begin
      case ({autoref_req, aref_done})
        2'b10: begin
          if (aref_cnt == MAX_CNT) aref_overflow <= 1'b1;
          else                     aref_cnt      <= aref_cnt + 1'b1;
        end
        2'b01:   aref_cnt <= aref_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // PRRD flag: a request in the completion cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      prrd_pend   <= 1'b0;
      autoref_ack <= 1'b0;
      pr_rd_ack   <= 1'b0;
    end else begin
      prrd_pend   <= pr_rd_req || (prrd_pend && !(finish && (win_type == GT_PRRD)));
      autoref_ack <= aref_done;
      pr_rd_ack   <= finish && (win_type == GT_PRRD);
    end
  end

`ifdef MAINT_ZQ_SCHED_EN
  // ZQ flag behaves like the PRRD flag
  always_ff @(posedge clk) begin
    if (rst) begin
      zq_pend <= 1'b0;
      zq_ack  <= 1'b0;
    end else begin
      zq_pend <= zq_req || (zq_pend && !(finish && (win_type == GT_ZQ)));
      zq_ack  <= finish && (win_type == GT_ZQ);
    end
  end
`else
  logic unused_zq_req;
  assign unused_zq_req = zq_req;
  assign zq_pend       = 1'b0;
  assign zq_ack        = 1'b0;
`endif

endmodule

// File: tb/tb_maint_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_maint_req_scheduler
// Self-checking bench for maint_req_scheduler with default parameters.
// A transaction-level model tracks refresh credits, request flags and the
// in-flight grant; every cycle all outputs are compared with it. Directed
// scenarios add hand-computed literal expectations.
// Honours MAINT_ZQ_SCHED_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_maint_req_scheduler;

  localparam int MAXP = 8;
`ifdef MAINT_ZQ_SCHED_EN
  localparam bit ZQ_EN = 1'b1;
`else
  localparam bit ZQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       autoref_req = 1'b0;
  logic       zq_req = 1'b0;
  logic       pr_rd_req = 1'b0;
  logic       dispatcher_busy = 1'b0;
  logic       grant_ack = 1'b0;
  logic       grant_done = 1'b0;
  logic       grant_valid;
  logic [1:0] grant_type;
  logic       autoref_ack;
  logic       zq_ack;
  logic       pr_rd_ack;
  logic [3:0] aref_pending;
  logic       aref_urgent;
  logic       aref_overflow;

  int check_count = 0;
  int fail_count  = 0;

  maint_req_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .autoref_req     (autoref_req),
    .zq_req          (zq_req),
    .pr_rd_req       (pr_rd_req),
    .dispatcher_busy (dispatcher_busy),
    .grant_valid     (grant_valid),
    .grant_type      (grant_type),
    .grant_ack       (grant_ack),
    .grant_done      (grant_done),
    .autoref_ack     (autoref_ack),
    .zq_ack          (zq_ack),
    .pr_rd_ack       (pr_rd_ack),
    .aref_pending    (aref_pending),
    .aref_urgent     (aref_urgent),
    .aref_overflow   (aref_overflow)
  );

  always #5 clk = ~clk;

  // Model state: outstanding work plus the grant currently handed out
  int m_credits  = 0;
  bit m_zq       = 1'b0;
  bit m_prrd     = 1'b0;
  bit m_ovf      = 1'b0;
  int m_inflight = -1;
  bit m_acked    = 1'b0;
  bit e_aref_ack = 1'b0;
  bit e_zq_ack   = 1'b0;
  bit e_prrd_ack = 1'b0;
  bit model_live = 1'b0;
  int m_pick;
  bit m_done_now;
  bit m_ack_now;

  // Which operation should be started now, or -1 for none
  function automatic int best_request(int credits, bit zq, bit prrd, bit busy);
    if (credits == MAXP) return 0;
    if (busy)            return -1;
    if (zq)              return 1;
    if (prrd)            return 2;
    if (credits > 0)     return 0;
    return -1;
  endfunction

  // Advance the model once per rising edge using the inputs of that cycle
  always @(posedge clk) begin
    model_live = 1'b1;
    if (rst) begin
      m_credits  = 0;
      m_zq       = 1'b0;
      m_prrd     = 1'b0;
      m_ovf      = 1'b0;
      m_inflight = -1;
      m_acked    = 1'b0;
      e_aref_ack = 1'b0;
      e_zq_ack   = 1'b0;
      e_prrd_ack = 1'b0;
    end else begin
      m_done_now = (m_inflight >= 0) && m_acked && grant_done;
      m_ack_now  = (m_inflight >= 0) && !m_acked && grant_ack;
      m_pick     = (m_inflight < 0) ? best_request(m_credits, m_zq, m_prrd, dispatcher_busy) : -1;
      e_aref_ack = m_done_now && (m_inflight == 0);
      e_zq_ack   = m_done_now && (m_inflight == 1);
      e_prrd_ack = m_done_now && (m_inflight == 2);
      if (autoref_req && !e_aref_ack) begin
        if (m_credits == MAXP) m_ovf = 1'b1;
        else                   m_credits++;
      end else if (!autoref_req && e_aref_ack) begin
        m_credits--;
      end
      m_zq   = (ZQ_EN && zq_req) || (m_zq && !e_zq_ack);
      m_prrd = pr_rd_req || (m_prrd && !e_prrd_ack);
      if (m_done_now) begin
        m_inflight = -1;
        m_acked    = 1'b0;
      end else if (m_ack_now) begin
        m_acked = 1'b1;
      end else if (m_pick >= 0) begin
        m_inflight = m_pick;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("mdl_grant_valid", int'(grant_valid), int'(m_inflight >= 0 && !m_acked));
      checkOutput("mdl_grant_type", int'(grant_type), (m_inflight >= 0 && !m_acked) ? m_inflight : 0);
      checkOutput("mdl_autoref_ack", int'(autoref_ack), int'(e_aref_ack));
      checkOutput("mdl_zq_ack", int'(zq_ack), int'(e_zq_ack));
      checkOutput("mdl_pr_rd_ack", int'(pr_rd_ack), int'(e_prrd_ack));
      checkOutput("mdl_aref_pending", int'(aref_pending), m_credits);
      checkOutput("mdl_aref_urgent", int'(aref_urgent), int'(m_credits == MAXP));
      checkOutput("mdl_aref_overflow", int'(aref_overflow), int'(m_ovf));
    end
  end

  // Drive one cycle of pulses, return at the following falling edge
  task automatic applyStimulus(input logic aref, input logic zq, input logic prrd,
                               input logic ack, input logic done);
    autoref_req = aref;
    zq_req      = zq;
    pr_rd_req   = prrd;
    grant_ack   = ack;
    grant_done  = done;
    @(negedge clk);
    autoref_req = 1'b0;
    zq_req      = 1'b0;
    pr_rd_req   = 1'b0;
    grant_ack   = 1'b0;
    grant_done  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_grant_valid", int'(grant_valid), 0);
    checkOutput("rst_aref_pending", int'(aref_pending), 0);
    checkOutput("rst_aref_overflow", int'(aref_overflow), 0);
    rst = 1'b0;

    // Stray ack/done with nothing granted
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("stray_ack_valid", int'(grant_valid), 0);
    checkOutput("stray_done_ack", int'(autoref_ack), 0);

    // Single refresh: grant two cycles after the request
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("aref_pending_1", int'(aref_pending), 1);
    checkOutput("aref_not_yet", int'(grant_valid), 0);
    idle(1);
    checkOutput("aref_grant_valid", int'(grant_valid), 1);
    checkOutput("aref_grant_type", int'(grant_type), 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("aref_valid_drop", int'(grant_valid), 0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("aref_ack_pulse", int'(autoref_ack), 1);
    checkOutput("aref_pending_0", int'(aref_pending), 0);
    idle(1);
    checkOutput("aref_ack_single", int'(autoref_ack), 0);

    // ZQ and PRRD together
    applyStimulus(0, 1, 1, 0, 0);
    idle(1);
`ifdef MAINT_ZQ_SCHED_EN
    checkOutput("zq_first_type", int'(grant_type), 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("zq_ack_pulse", int'(zq_ack), 1);
    checkOutput("zq_prrd_not_acked", int'(pr_rd_ack), 0);
    idle(1);
`endif
    checkOutput("prrd_grant_valid", int'(grant_valid), 1);
    checkOutput("prrd_grant_type", int'(grant_type), 2);
    // Later AREF and repeated PRRD must not disturb the held grant
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("prrd_hold_type", int'(grant_type), 2);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("prrd_hold_valid", int'(grant_valid), 1);
    applyStimulus(0, 0, 0, 1, 0);
    // New PRRD in the completion cycle keeps the flag
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("prrd_ack_pulse", int'(pr_rd_ack), 1);
    idle(1);
    checkOutput("prrd_regrant_type", int'(grant_type), 2);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idle(1);
    checkOutput("aref_after_prrd", int'(grant_type), 0);
    checkOutput("aref_after_prrd_v", int'(grant_valid), 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idle(2);
    checkOutput("all_drained", int'(grant_valid), 0);

    // ZQ alone
    applyStimulus(0, 1, 0, 0, 0);
    idle(1);
`ifdef MAINT_ZQ_SCHED_EN
    checkOutput("zq_alone_type", int'(grant_type), 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("zq_alone_ack", int'(zq_ack), 1);
`else
    checkOutput("zq_ignored_valid", int'(grant_valid), 0);
    idle(2);
    checkOutput("zq_ignored_ack", int'(zq_ack), 0);
`endif
    idle(1);

    // Busy bus: only the eighth refresh forces a grant
    dispatcher_busy = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 0);
    idle(1);
    checkOutput("busy_pending_7", int'(aref_pending), 7);
    checkOutput("busy_no_grant", int'(grant_valid), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("busy_urgent", int'(aref_urgent), 1);
    idle(1);
    checkOutput("urgent_grant_valid", int'(grant_valid), 1);
    checkOutput("urgent_grant_type", int'(grant_type), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("sat_pending_8", int'(aref_pending), 8);
    checkOutput("sat_overflow", int'(aref_overflow), 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sat_done_pending", int'(aref_pending), 7);
    checkOutput("ovf_sticky", int'(aref_overflow), 1);
    idle(2);
    checkOutput("busy_nonurgent_wait", int'(grant_valid), 0);

    // Reset while issuing abandons the grant silently
    dispatcher_busy = 1'b0;
    idle(1);
    checkOutput("free_grant_valid", int'(grant_valid), 1);
    applyStimulus(0, 0, 0, 1, 0);
    rst        = 1'b1;
    grant_done = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    grant_done = 1'b0;
    checkOutput("rst_issue_ack", int'(autoref_ack), 0);
    checkOutput("rst_issue_pending", int'(aref_pending), 0);
    checkOutput("rst_issue_ovf", int'(aref_overflow), 0);
    applyStimulus(0, 0, 1, 0, 0);
    idle(1);
    checkOutput("post_rst_type", int'(grant_type), 2);
    checkOutput("post_rst_valid", int'(grant_valid), 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("post_rst_ack", int'(pr_rd_ack), 1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
